crossbar_target: RTL

Memory-mapped responder at the slave end of the 2x2 crossbar. Sits behind one arbiter instance and accepts the arbiter's registered req/cmd/addr/wdata. Performs a read or write on a local word-addressed RAM after a fixed, parameterised latency. Returns a one-cycle ack with read data and an error flag.

---
 rtl/crossbar_pkg.sv | 17 +
 rtl/crossbar_target_if.sv | 17 +
 rtl/crossbar_target_mem.sv | 28 ++
 rtl/crossbar_target.sv | 97 +++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// crossbar_pkg: widths, command codes and target state encoding shared by the crossbar blocks
package crossbar_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // 2'd3 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/crossbar_target_if.sv
// crossbar_target_if: arbiter-to-target request/response bundle
interface crossbar_target_if;
    import crossbar_pkg::*;

    logic              req;
    logic              cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;

    modport master (output req, cmd, addr, wdata, input ack, rdata, err, busy);
    modport slave  (input req, cmd, addr, wdata, output ack, rdata, err, busy);

endinterface

// File: rtl/crossbar_target_mem.sv
// crossbar_target_mem: single-port synchronous RAM with one-cycle registered read, no reset
module crossbar_target_mem
    import crossbar_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_q;

    // Write or read the addressed word when enabled; read data holds otherwise
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem_q[idx] <= wdata;
            else    rdata_q    <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/crossbar_target.sv
// crossbar_target: word-addressed RAM responder with fixed latency behind one crossbar arbiter
module crossbar_target
    import crossbar_pkg::*;
#(
    parameter int unsigned SLAVE_ID   = 0,
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned LATENCY    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    crossbar_target_if.slave bus
);

    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ack_q;
    logic              err_q;
    logic              rd_q;
    logic              busy_q;

    logic [ADDR_W-1:0] dec_addr;
    logic              dec_cmd;
    logic              hit;
    logic              go_resp;
    logic              wr_slot;
    logic              mem_en;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_lsb;

    // In IDLE the live inputs are decoded so a zero-latency read can hit the RAM in the capture cycle
    assign dec_addr   = (state_q == IDLE) ? bus.addr : addr_q;
    assign dec_cmd    = (state_q == IDLE) ? bus.cmd  : cmd_q;
    assign hit        = (dec_addr[ADDR_W-1] == SLAVE_ID[0]) && ~|dec_addr[ADDR_W-2:DEPTH_LOG2+2];
    assign go_resp    = (state_q == WAIT && cnt_q == 4'd0) || (state_q == IDLE && bus.req && LATENCY == 0);
    assign wr_slot    = (state_q == RESP) && (cmd_q == CMD_WRITE);
    assign mem_en     = hit && ((go_resp && dec_cmd == CMD_READ) || wr_slot);
    assign unused_lsb = ^dec_addr[1:0];

    crossbar_target_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (wr_slot),
        .idx   (dec_addr[DEPTH_LOG2+1:2]),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    // Sequencer: capture in IDLE, count down in WAIT, present a one-cycle response in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            cmd_q   <= CMD_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= go_resp;
            err_q <= go_resp && !hit;
            rd_q  <= go_resp && hit && dec_cmd == CMD_READ;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        cmd_q   <= bus.cmd;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        cnt_q   <= LAT_M1;
                        state_q <= (LATENCY == 0) ? RESP : WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) state_q <= RESP;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
    assign bus.rdata = rd_q ? mem_rdata : '0;

endmodule
